alu_op_sequencer: RTL

- Upstream feeder for the ALU DUT.
- Accepts complete operation requests over a valid/ready handshake and drives the ALU input pins (OPA, OPB, CMD, MODE, CIN, CE, INP_VALID).
- Can deliver operands together or split across a programmable gap, exercising the ALU's 16-cycle operand window.
- Waits a command-dependent latency, captures RES and flags, and returns them as a response record under valid/ready.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_seq_timer.sv | 17 +
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared state, command, INP_VALID and flag-index definitions for the ALU sequencer
package alu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE_A, S_GAP, S_ISSUE_B, S_WAIT, S_HOLD} seq_state_e;
  localparam int CMD_MUL_INC = 9;
  localparam int CMD_MUL_SHL = 10;
  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;
  localparam int FLAG_E     = 0;
  localparam int FLAG_L     = 1;
  localparam int FLAG_G     = 2;
  localparam int FLAG_COUT  = 3;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_ERR   = 5;
  localparam int TIMER_W    = 4;
endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: loadable down-counter whose done output is high while it reads 1
module alu_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == W'(1);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives ALU pins from valid/ready requests and returns RES/flags after a command-dependent latency; ALU_SEQ_STATS_EN adds issue/error counters
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CMD_W     = 4,
  parameter int ARITH_LAT = 1,
  parameter int MUL_LAT   = 2,
  parameter int MAX_GAP   = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [WIDTH-1:0]   REQ_OPA,
  input  logic [WIDTH-1:0]   REQ_OPB,
  input  logic [CMD_W-1:0]   REQ_CMD,
  input  logic               REQ_MODE,
  input  logic               REQ_CIN,
  input  logic               REQ_SPLIT,
  input  logic [3:0]         REQ_GAP,
  output logic [WIDTH-1:0]   OPA,
  output logic [WIDTH-1:0]   OPB,
  output logic [CMD_W-1:0]   CMD,
  output logic               MODE,
  output logic               CIN,
  output logic               CE,
  output logic [1:0]         INP_VALID,
  input  logic [2*WIDTH-1:0] RES,
  input  logic               COUT,
  input  logic               OFLOW,
  input  logic               G,
  input  logic               L,
  input  logic               E,
  input  logic               ERR,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [2*WIDTH-1:0] RSP_RES,
  output logic [5:0]         RSP_FLAGS,
  output logic [15:0]        STAT_ISSUED,
  output logic [15:0]        STAT_ERR
);
  seq_state_e state, state_d;
  logic [WIDTH-1:0] opa_d, opb_d, opb_hold, opb_hold_d;
  logic [CMD_W-1:0] cmd_d;
  logic [TIMER_W-1:0] gap_q, gap_d, lat_val;
  logic [2*WIDTH-1:0] rsp_res_d;
  logic [5:0] cap_flags, rsp_flags_d;
  logic [1:0] iv_d;
  logic mode_d, cin_d, ce_d, req_ready_d, rsp_valid_d;
  logic gap_load, lat_load, gap_done, lat_done, is_mul;
  assign is_mul = MODE && (CMD == CMD_W'(CMD_MUL_INC) || CMD == CMD_W'(CMD_MUL_SHL));
  assign lat_val = is_mul ? TIMER_W'(MUL_LAT) : TIMER_W'(ARITH_LAT);
  alu_seq_timer #(.W(TIMER_W)) u_gap (.clk(CLK), .rst(RST), .load(gap_load), .val(gap_q), .done(gap_done));
  alu_seq_timer #(.W(TIMER_W)) u_lat (.clk(CLK), .rst(RST), .load(lat_load), .val(lat_val), .done(lat_done));
  always_comb begin
    cap_flags = '0;
    cap_flags[FLAG_E] = E;
    cap_flags[FLAG_L] = L;
    cap_flags[FLAG_G] = G;
    cap_flags[FLAG_COUT] = COUT;
    cap_flags[FLAG_OFLOW] = OFLOW;
    cap_flags[FLAG_ERR] = ERR;
  end
  always_comb begin
    state_d = state;
    req_ready_d = REQ_READY;
    opa_d = OPA;
    opb_d = OPB;
    opb_hold_d = opb_hold;
    cmd_d = CMD;
    mode_d = MODE;
    cin_d = CIN;
    ce_d = CE;
    iv_d = IV_NONE;
    rsp_valid_d = RSP_VALID;
    rsp_res_d = RSP_RES;
    rsp_flags_d = RSP_FLAGS;
    gap_d = gap_q;
    gap_load = 1'b0;
    lat_load = 1'b0;
    case (state)
      S_IDLE: if (REQ_VALID) begin
        state_d = REQ_SPLIT ? S_ISSUE_A : S_ISSUE_B;
        req_ready_d = 1'b0;
        ce_d = 1'b1;
        iv_d = REQ_SPLIT ? IV_A : IV_AB;
        opa_d = REQ_OPA;
        opb_d = REQ_SPLIT ? '0 : REQ_OPB;
        opb_hold_d = REQ_OPB;
        cmd_d = REQ_CMD;
        mode_d = REQ_MODE;
        cin_d = REQ_CIN;
        gap_d = REQ_GAP > TIMER_W'(MAX_GAP) ? TIMER_W'(MAX_GAP) : REQ_GAP;
      end
      S_ISSUE_A: begin
        gap_load = 1'b1;
        state_d = gap_q == '0 ? S_ISSUE_B : S_GAP;
      end
      S_GAP: state_d = gap_done ? S_ISSUE_B : S_GAP;
      S_ISSUE_B: begin
        lat_load = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (lat_done) begin
        state_d = S_HOLD;
        ce_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_res_d = RES;
        rsp_flags_d = cap_flags;
      end
      S_HOLD: if (RSP_READY) begin
        state_d = S_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state == S_ISSUE_A || state == S_GAP) && state_d == S_ISSUE_B) begin
      iv_d = IV_B;
      opb_d = opb_hold;
    end
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state <= S_IDLE;
      REQ_READY <= 1'b1;
      OPA <= '0;
      OPB <= '0;
      CMD <= '0;
      MODE <= 1'b0;
      CIN <= 1'b0;
      CE <= 1'b0;
      INP_VALID <= IV_NONE;
      RSP_VALID <= 1'b0;
      RSP_RES <= '0;
      RSP_FLAGS <= '0;
      opb_hold <= '0;
      gap_q <= '0;
    end else begin
      state <= state_d;
      REQ_READY <= req_ready_d;
      OPA <= opa_d;
      OPB <= opb_d;
      CMD <= cmd_d;
      MODE <= mode_d;
      CIN <= cin_d;
      CE <= ce_d;
      INP_VALID <= iv_d;
      RSP_VALID <= rsp_valid_d;
      RSP_RES <= rsp_res_d;
      RSP_FLAGS <= rsp_flags_d;
      opb_hold <= opb_hold_d;
      gap_q <= gap_d;
    end
`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge CLK)
    if (RST) begin
      STAT_ISSUED <= '0;
      STAT_ERR <= '0;
    end else begin
      if (state == S_ISSUE_B && STAT_ISSUED != 16'hFFFF) STAT_ISSUED <= STAT_ISSUED + 16'd1;
      if (state == S_WAIT && lat_done && ERR && STAT_ERR != 16'hFFFF) STAT_ERR <= STAT_ERR + 16'd1;
    end
`else
  assign STAT_ISSUED = '0;
  assign STAT_ERR = '0;
`endif
endmodule
